// File: rtl/block_ram_dp.sv
`default_nettype none
// ============================================================================
// Module      : block_ram_dp
// Description : Simple dual-port block RAM for the Cortex-M0 SoC code/data
//               memory. Port A writes with per-byte enables; port B reads
//               with an enable. Generic width/depth, optional output
//               pipeline register, selectable read-during-write collision
//               behaviour, a read-valid flag and an optional reset-triggered
//               clear sequencer.
//
// Ports       : clka    - clock, all logic on the rising edge
//               rsta    - synchronous active-high reset
//               addra   - port A (write) word address
//               dina    - port A write data
//               wea     - port A byte-lane write enables
//               addrb   - port B (read) word address
//               enb     - port B read request
//               doutb   - port B read data
//               validb  - one-cycle pulse, doutb holds a fresh read result
//               busy    - clear sequence running, port A/B requests ignored
//
// Revision    : 1.0 - initial release
// ============================================================================
module block_ram_dp #(
    parameter int    ADDR_WIDTH     = 14,
    parameter int    DATA_WIDTH     = 32,
    parameter int    OUT_REG        = 0,
    parameter int    BYPASS         = 1,
    parameter int    CLEAR_ON_RESET = 0,
    parameter string INIT_FILE      = ""
) (
    input  logic                      clka,
    input  logic                      rsta,
    input  logic [ADDR_WIDTH-1:0]     addra,
    input  logic [DATA_WIDTH-1:0]     dina,
    input  logic [DATA_WIDTH/8-1:0]   wea,
    input  logic [ADDR_WIDTH-1:0]     addrb,
    input  logic                      enb,
    output logic [DATA_WIDTH-1:0]     doutb,
    output logic                      validb,
    output logic                      busy
);

    localparam int c_NB    = DATA_WIDTH / 8;
    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    logic                  w_busy;
    logic [ADDR_WIDTH-1:0] w_clr_addr;

    if (CLEAR_ON_RESET != 0) begin : g_clear
        localparam logic [0:0]            c_ST_IDLE  = 1'b0;
        localparam logic [0:0]            c_ST_CLEAR = 1'b1;
        localparam logic [ADDR_WIDTH-1:0] c_LAST     = '1;

        logic [0:0]            r_state;
        logic [0:0]            w_state_nxt;
        logic [ADDR_WIDTH-1:0] r_cnt;
        logic [ADDR_WIDTH-1:0] w_cnt_nxt;

        always_ff @(posedge clka) begin
            if (rsta) begin
                r_state <= c_ST_CLEAR;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // The word at c_LAST is written on the same edge that leaves CLEAR,
        // so busy drops exactly DEPTH edges after reset is released.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            if (r_state == c_ST_CLEAR) begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
        end

        assign w_busy     = (r_state == c_ST_CLEAR);
        assign w_clr_addr = r_cnt;
    end else begin : g_no_clear
        assign w_busy     = 1'b0;
        assign w_clr_addr = '0;
    end

    // ------------------------------------------------------------------
    // Write port mux: the clear sequencer borrows port A, keeping a single
    // write port on the array.
    // ------------------------------------------------------------------
    logic [c_NB-1:0]       w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;

    always_comb begin
        w_wr_en   = '0;
        w_wr_addr = addra;
        w_wr_data = dina;
        if (w_busy) begin
            if (!rsta) begin
                w_wr_en = '1;
            end
            w_wr_addr = w_clr_addr;
            w_wr_data = '0;
        end else begin
            w_wr_en = wea;
        end
    end

    // Read requests are dropped while clearing or in reset.
    logic w_rd_en;
    assign w_rd_en = enb && !w_busy && !rsta;

    // ------------------------------------------------------------------
    // Array access. The read register has no reset so the array plus this
    // register map onto a block RAM primitive; the natural NBA ordering
    // gives read-first data on an address collision.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_rd_raw;

    always_ff @(posedge clka) begin
        for (int i = 0; i < c_NB; i++) begin
            if (w_wr_en[i]) begin
                r_mem[w_wr_addr][i*8 +: 8] <= w_wr_data[i*8 +: 8];
            end
        end
        if (w_rd_en) begin
            r_rd_raw <= r_mem[addrb];
        end
    end

    // ------------------------------------------------------------------
    // Collision handling, kept outside the RAM: write-first is built by
    // registering the colliding lanes and data alongside the read.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rd_data;

    if (BYPASS != 0) begin : g_bypass
        logic [c_NB-1:0]       r_col_lanes;
        logic [DATA_WIDTH-1:0] r_col_data;

        always_ff @(posedge clka) begin
            if (w_rd_en) begin
                r_col_lanes <= (addra == addrb) ? wea : '0;
                r_col_data  <= dina;
            end
        end

        always_comb begin
            w_rd_data = r_rd_raw;
            for (int i = 0; i < c_NB; i++) begin
                if (r_col_lanes[i]) begin
                    w_rd_data[i*8 +: 8] = r_col_data[i*8 +: 8];
                end
            end
        end
    end else begin : g_read_first
        assign w_rd_data = r_rd_raw;
    end

    // ------------------------------------------------------------------
    // Read valid pipeline
    // ------------------------------------------------------------------
    logic r_v1;

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_rd_en;
        end
    end

    if (OUT_REG == 0) begin : g_out_direct
        // The un-resettable RAM register is masked to zero after reset
        // until the first accepted read refreshes it.
        logic r_zero;

        always_ff @(posedge clka) begin
            if (rsta) begin
                r_zero <= 1'b1;
            end else if (w_rd_en) begin
                r_zero <= 1'b0;
            end
        end

        assign doutb  = r_zero ? '0 : w_rd_data;
        assign validb = r_v1;
    end else begin : g_out_reg
        logic [DATA_WIDTH-1:0] r_dout;
        logic                  r_v2;

        always_ff @(posedge clka) begin
            if (rsta) begin
                r_dout <= '0;
                r_v2   <= 1'b0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_dout <= w_rd_data;
                end
            end
        end

        assign doutb  = r_dout;
        assign validb = r_v2;
    end

    assign busy = w_busy;

endmodule
`default_nettype wire
